// File: rtl/alu_seq_pkg.sv
// Shared opcode/state definitions and opcode classification for the ALU step sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_NEG   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_OR    = 4'h5;
  localparam logic [3:0] OP_XOR   = 4'h6;
  localparam logic [3:0] OP_NOT   = 4'h7;
  localparam logic [3:0] OP_ROR   = 4'h8;
  localparam logic [3:0] OP_ROL   = 4'h9;
  localparam logic [3:0] OP_ASL   = 4'hA;
  localparam logic [3:0] OP_ASR   = 4'hB;
  localparam logic [3:0] OP_IDAND = 4'hC;

  typedef enum logic [2:0] {
    ST_OPCODE   = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_LOAD_B   = 3'd2,
    ST_EXEC     = 3'd3,
    ST_MUL_ITER = 3'd4,
    ST_SHOW     = 3'd5
  } state_t;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_IDAND;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier. The first partial product is folded into
// the start cycle so DW iterations finish DW-1 cycles after start; done follows one cycle later.
module shift_add_mul #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DW-1:0]     a,
  input  logic [DW-1:0]     b,
  output logic              busy,
  output logic              done,
  output logic [2*DW-1:0]   product
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [2*DW-1:0] acc, mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= b[0] ? {{DW{1'b0}}, a} : '0;
        mcand  <= {{(DW-1){1'b0}}, a, 1'b0};
        mplier <= b >> 1;
        cnt    <= CW'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (cnt == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/alu_step_sequencer.sv
// Button-stepped multi-cycle ALU: OPCODE -> A -> (B) -> EXEC/MUL -> SHOW.
// Define ALU_STATUS_FLAGS_EN to add registered flag_z/flag_n/flag_c outputs.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int              DW          = 8,
  parameter logic [2*DW-1:0] ID_CONST    = 16'h4813,
  parameter int              SYNC_STAGES = 2
) (
  input  logic              CLOCK_50,
  input  logic              KEY_rst_n,
  input  logic              step_n,
  input  logic [DW-1:0]     sw,
  output logic [2:0]        state_o,
  output logic [3:0]        opcode_o,
  output logic [2*DW-1:0]   result_o,
  output logic              busy,
  output logic              err
`ifdef ALU_STATUS_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
`endif
);

  localparam int RW = 2 * DW;
  localparam logic [DW-1:0] DW_V = DW'(DW);

  state_t          state, state_d;
  logic [DW-1:0]   a, b, sh, ror_v, rol_v, asr_v;
  logic [SYNC_STAGES-1:0] sync;
  logic            edge_q, step;
  logic            ld_op, ld_a, ld_b, wr_res, mul_start, mul_busy, mul_done;
  logic [RW-1:0]   mul_prod, alu_res, res_d;

  // Step button: synchronise, then fire once on the falling edge.
  always_ff @(posedge CLOCK_50 or negedge KEY_rst_n) begin
    if (!KEY_rst_n) begin
      sync   <= '0;
      edge_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], step_n};
      edge_q <= sync[SYNC_STAGES-1];
    end
  end

  assign step = edge_q & ~sync[SYNC_STAGES-1];

  shift_add_mul #(.DW(DW)) u_mul (
    .clk     (CLOCK_50),
    .rst_n   (KEY_rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    sh    = b % DW_V;
    ror_v = DW'({a, a} >> sh);
    rol_v = DW'(({a, a} << sh) >> DW);
    asr_v = $signed(a) >>> sh;
    alu_res = '0;
    case (opcode_o)
      OP_ADD:   alu_res = {{DW{1'b0}}, a} + {{DW{1'b0}}, b};
      OP_SUB:   alu_res = {{DW{1'b0}}, a} - {{DW{1'b0}}, b};
      OP_NEG:   alu_res = '0 - {{DW{1'b0}}, a};
      OP_AND:   alu_res = {{DW{1'b0}}, a & b};
      OP_OR:    alu_res = {{DW{1'b0}}, a | b};
      OP_XOR:   alu_res = {{DW{1'b0}}, a ^ b};
      OP_NOT:   alu_res = {{DW{1'b0}}, ~a};
      OP_ROR:   alu_res = {{DW{1'b0}}, ror_v};
      OP_ROL:   alu_res = {{DW{1'b0}}, rol_v};
      OP_ASL:   alu_res = {{DW{1'b0}}, a << sh};
      OP_ASR:   alu_res = {{DW{1'b0}}, asr_v};
      OP_IDAND: alu_res = {a, b} & ID_CONST;
      default:  alu_res = '0;
    endcase
    res_d = (state == ST_MUL_ITER) ? mul_prod : alu_res;
  end

  // Step pulses in EXEC/MUL_ITER are simply not looked at, so they drop.
  always_comb begin
    state_d   = state;
    ld_op     = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    wr_res    = 1'b0;
    mul_start = 1'b0;
    case (state)
      ST_OPCODE: if (step) begin
        ld_op   = 1'b1;
        state_d = ST_LOAD_A;
      end
      ST_LOAD_A: if (step) begin
        ld_a    = 1'b1;
        state_d = (is_unary(opcode_o) || !is_legal(opcode_o)) ? ST_EXEC : ST_LOAD_B;
      end
      ST_LOAD_B: if (step) begin
        ld_b    = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (opcode_o == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL_ITER;
        end else begin
          wr_res  = 1'b1;
          state_d = ST_SHOW;
        end
      end
      ST_MUL_ITER: if (mul_done) begin
        wr_res  = 1'b1;
        state_d = ST_SHOW;
      end
      ST_SHOW: if (step) state_d = ST_OPCODE;
      default: state_d = ST_OPCODE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY_rst_n) begin
    if (!KEY_rst_n) state <= ST_OPCODE;
    else            state <= state_d;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY_rst_n) begin
    if (!KEY_rst_n) begin
      opcode_o <= '0;
      a        <= '0;
      b        <= '0;
      result_o <= '0;
      err      <= 1'b0;
    end else begin
      if (ld_op) begin
        opcode_o <= sw[3:0];
        err      <= 1'b0;
      end
      if (ld_a) a <= sw;
      if (ld_b) b <= sw;
      if (wr_res) begin
        result_o <= res_d;
        err      <= !is_legal(opcode_o);
      end
    end
  end

`ifdef ALU_STATUS_FLAGS_EN
  logic carry_d;

  always_comb begin
    case (opcode_o)
      OP_ADD:  carry_d = alu_res[DW];
      OP_SUB:  carry_d = a < b;
      OP_MUL:  carry_d = |mul_prod[RW-1:DW];
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY_rst_n) begin
    if (!KEY_rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (ld_op) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (wr_res) begin
      flag_z <= (res_d == '0);
      flag_n <= res_d[RW-1];
      flag_c <= carry_d;
    end
  end
`endif

  assign state_o = state;
  assign busy    = (state == ST_EXEC) | mul_busy | mul_done;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Scoreboard bench: each stepped operation queues its expected outcome; a monitor
// pops and compares whenever the sequencer enters SHOW.
module tb_alu_step_sequencer;

  localparam int DW = 8;
  localparam int RW = 16;

  logic          CLOCK_50 = 1'b0;
  logic          KEY_rst_n = 1'b0;
  logic          step_n = 1'b1;
  logic [DW-1:0] sw = '0;
  logic [2:0]    state_o;
  logic [3:0]    opcode_o;
  logic [RW-1:0] result_o;
  logic          busy, err;
`ifdef ALU_STATUS_FLAGS_EN
  logic          flag_z, flag_n, flag_c;
`endif

  typedef struct {
    logic [3:0]    op;
    logic [RW-1:0] res;
    logic          err;
    logic          saw_b;
    int            busy_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  alu_step_sequencer #(.DW(DW), .ID_CONST(16'h4813), .SYNC_STAGES(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY_rst_n (KEY_rst_n),
    .step_n    (step_n),
    .sw        (sw),
    .state_o   (state_o),
    .opcode_o  (opcode_o),
    .result_o  (result_o),
    .busy      (busy),
    .err       (err)
`ifdef ALU_STATUS_FLAGS_EN
    ,
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: track LOAD_B visits and busy length, compare on SHOW entry.
  logic [2:0] prev_st = 3'd0;
  logic       saw_b = 1'b0;
  int         bcnt = 0;

  always @(negedge CLOCK_50) begin
    if (!KEY_rst_n) begin
      saw_b   = 1'b0;
      bcnt    = 0;
      prev_st = 3'd0;
    end else begin
      if (state_o == 3'd0) begin
        saw_b = 1'b0;
        bcnt  = 0;
      end
      if (state_o == 3'd2) saw_b = 1'b1;
      if (busy) bcnt++;
      if (state_o == 3'd5 && prev_st != 3'd5) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_show: got result %0h with empty queue", result_o);
        end else begin
          mon_e = sb.pop_front();
          check("result", result_o, mon_e.res);
          check("err", err, mon_e.err);
          check("opcode", opcode_o, mon_e.op);
          check("visited_load_b", saw_b, mon_e.saw_b);
          check("busy_cycles", bcnt, mon_e.busy_cyc);
        end
      end
      prev_st = state_o;
    end
  end

  task automatic press(input logic [DW-1:0] v, input int hold);
    @(negedge CLOCK_50);
    sw     = v;
    step_n = 1'b0;
    repeat (hold) @(negedge CLOCK_50);
    step_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int n;
    n = 0;
    while (state_o !== s && n < 60) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(name, state_o, s);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic [RW-1:0] res, input logic e, input logic has_b,
                       input int bc, input logic inject);
    sb.push_back('{op: op, res: res, err: e, saw_b: has_b, busy_cyc: bc});
    press({4'h0, op}, 3);
    press(av, 3);
    if (has_b) press(bv, 3);
    if (inject) press(8'hA5, 3);
    wait_state(3'd5, "reach_show");
    if (inject) begin
      repeat (10) @(negedge CLOCK_50);
      check("show_after_busy_step", state_o, 3'd5);
    end
    press('0, 3);
    check("back_to_opcode", state_o, 3'd0);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge CLOCK_50);
    #2 KEY_rst_n = 1'b0;
    #1;
    check({name, "_state"}, state_o, 3'd0);
    check({name, "_result"}, result_o, 16'h0000);
    check({name, "_opcode"}, opcode_o, 4'h0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_err"}, err, 1'b0);
    @(negedge CLOCK_50);
    KEY_rst_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("rst_state", state_o, 3'd0);
    check("rst_result", result_o, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    KEY_rst_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    check("post_rst_state", state_o, 3'd0);

    //    op    A      B      result    err  B?  busy inject
    do_op(4'h0, 8'd10, 8'd5,  16'h000F, 0,   1,  1,   0);  // ADD
    do_op(4'h1, 8'd7,  8'd12, 16'hFFFB, 0,   1,  1,   0);  // SUB
    do_op(4'h2, 8'd9,  8'd0,  16'hFFF7, 0,   0,  1,   0);  // NEG
    do_op(4'h7, 8'h55, 8'd0,  16'h00AA, 0,   0,  1,   0);  // NOT
    do_op(4'h3, 8'd200,8'd200,16'h9C40, 0,   1,  9,   1);  // MUL
    do_op(4'h8, 8'h81, 8'd3,  16'h0030, 0,   1,  1,   0);  // ROR
    do_op(4'h9, 8'h81, 8'd2,  16'h0006, 0,   1,  1,   0);  // ROL
    do_op(4'hA, 8'hF0, 8'd2,  16'h00C0, 0,   1,  1,   0);  // ASL
    do_op(4'hB, 8'hF0, 8'd2,  16'h00FC, 0,   1,  1,   0);  // ASR
    do_op(4'h8, 8'h81, 8'd8,  16'h0081, 0,   1,  1,   0);  // ROR by DW
    do_op(4'h9, 8'h81, 8'd9,  16'h0003, 0,   1,  1,   0);  // ROL by DW+1
    do_op(4'hC, 8'h48, 8'h13, 16'h4813, 0,   1,  1,   0);  // IDAND
    do_op(4'h4, 8'hF0, 8'h3C, 16'h0030, 0,   1,  1,   0);  // AND
    do_op(4'h6, 8'hF0, 8'h3C, 16'h00CC, 0,   1,  1,   0);  // XOR
    do_op(4'h3, 8'd15, 8'd0,  16'h0000, 0,   1,  9,   0);  // MUL by zero

    // Long hold gives exactly one step.
    sb.push_back('{op: 4'h0, res: 16'h0007, err: 1'b0, saw_b: 1'b1, busy_cyc: 1});
    press(8'h00, 50);
    check("held_step_once", state_o, 3'd1);
    press(8'd3, 3);
    press(8'd4, 3);
    wait_state(3'd5, "held_reach_show");
    press('0, 3);

    // Reset while waiting for B.
    press(8'h03, 3);
    press(8'd200, 3);
    check("in_load_b", state_o, 3'd2);
    async_reset_check("rst_load_b");

    // Reset mid-multiply leaves nothing behind.
    press(8'h03, 3);
    press(8'd200, 3);
    press(8'd200, 1);
    check("in_mul_iter", state_o, 3'd4);
    async_reset_check("rst_mul_iter");
    repeat (12) @(negedge CLOCK_50);
    check("no_partial_result", result_o, 16'h0000);
    check("idle_after_abort", state_o, 3'd0);

    // Illegal opcode, err persists until the next OPCODE step.
    do_op(4'hE, 8'h12, 8'h00, 16'h0000, 1, 0, 1, 0);
    check("err_held_in_opcode", err, 1'b1);
    press(8'h00, 3);
    check("err_cleared", err, 1'b0);

    repeat (5) @(negedge CLOCK_50);
    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
